bcd_disp_mux: RTL and testbench
===============================

// Module: bcd_disp_mux
// PURPOSE
//  Display-side consumer of the 3-digit BCD count (dig1 = ones, dig2 = tens, dig3 = hundreds).
//  Time-multiplexes the three digits onto a 4-digit common-anode 7-segment display.
//  Digits are snapshotted once per scan frame so a count changing mid-scan never tears.
//  Sits between the BCD counter outputs and the board seg/an pins.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles per digit slot; legal range >= 2
//  BLANK_CYCLES  500    anode-off cycles at the start of each slot (anti-ghosting); legal range 1..REFRESH_DIV-1
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  ar          in   1  asynchronous reset, active-low
//  en          in   1  scan enable; when low, the display is dark and the scanner is parked
//  dig1        in   4  BCD ones digit
//  dig2        in   4  BCD tens digit
//  dig3        in   4  BCD hundreds digit
//  seg         out  7  {g,f,e,d,c,b,a}; active-low
//  an          out  4  digit anodes; active-low; an[3] held 1
//  frame_tick  out  1  1-cycle pulse: snapshot taken this frame
// BEHAVIOUR
//  Reset (ar low, async): an=4'b1111, seg=7'b1111111, frame_tick=0, slot=S1, div=0, shadow digits=0.
//  State:
//   - div counter, width $clog2(REFRESH_DIV).
//   - slot FSM with states S1 (an[0], dig1), S2 (an[1], dig2), S3 (an[2], dig3).
//   - Slot sequence S1->S2->S3->S1.
//  en=1, per clk:
//   - If div==REFRESH_DIV-1: div<=0 and slot advances.
//   - Otherwise: div<=div+1.
//  Snapshot:
//   - When en && slot==S1 && div==0, shadow<={dig3,dig2,dig1} and frame_tick<=1.
//   - frame_tick<=0 on every other cycle.
//  Outputs are registered:
//   - At each edge, an/seg <= f(pre-edge slot, div, shadow), giving 1-cycle latency.
//   - Slot active when div>=BLANK_CYCLES: that slot's anode is low and seg shows its shadow digit.
//   - Slot not active: an=4'b1111 and seg=7'b1111111.
//   - Because BLANK_CYCLES>=1, the stale shadow is never shown at the snapshot edge.
//  Decode (seg, active-low):
//   - 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001
//   - 5:0010010  6:0000010  7:1111000  8:0000000  9:0010000
//   - Values 10-15 (invalid BCD) show dash 0111111.
//  en=0:
//   - At the next edge: div<=0, slot<=S1, an=1111, seg=1111111, frame_tick=0.
//   - Shadow is held.
//   - When en returns high, the first enabled cycle takes a snapshot, so the frame restarts cleanly.
//  Frame period = 3*REFRESH_DIV cycles. Per slot, the anode is low for REFRESH_DIV-BLANK_CYCLES cycles.
//  Inputs change mid-frame: ignored until the next frame_tick.
//  Reset mid-frame: immediate dark display; restart at S1 after release.
// CONFIGURATION
//  BCD_DISP_LZB_EN defined (leading-zero blanking):
//   - Slot S3 stays dark (an[2]=1) when shadow dig3==0.
//   - Slot S2 stays dark when shadow dig3==0 && dig2==0.
//   - S1 is always shown, so a count of 0 displays "0".
//   - Timing is unchanged; blanked slots still consume REFRESH_DIV cycles.
//  BCD_DISP_LZB_EN undefined: all three digits are always shown, including zeros.
// TESTING (REFRESH_DIV=8, BLANK_CYCLES=2)
//  1. ar=0 with any inputs -> an=1111, seg=1111111, frame_tick=0. Release ar, en=0 -> outputs stay dark.
//  2. dig3=3, dig2=2, dig1=1, en=1 -> frame_tick pulse; then per slot 2 dark cycles + 6 lit cycles:
//     an=1110 seg=1111001, an=1101 seg=0100100, an=1011 seg=0110000. Frame repeats every 24 cycles.
//  3. Change to dig1=9 during S2 -> current frame still shows 1. After the next frame_tick, S1 shows 0010000.
//  4. dig2=4'hC -> S2 lit cycles show seg=0111111.
//  5. dig={0,0,7}:
//     - LZB_EN defined: an[2:1] stay 1 for the whole frame; S1 shows 1111000.
//     - LZB_EN undefined: S2 and S3 show 1000000.
//  6. en=0 at div=4 of S2 -> next edge dark, div=0, slot=S1. en=1 -> frame_tick on the first cycle, S1 restarts.
//     ar pulse mid-slot -> immediate dark.

Source files
------------

// File: rtl/bcd_disp_mux.sv
// Time-multiplexed 3-digit BCD driver for a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled with `define BCD_DISP_LZB_EN.
module bcd_disp_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       en,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK_CYCLES);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  typedef enum logic [1:0] {
    S1 = 2'd0,
    S2 = 2'd1,
    S3 = 2'd2
  } slot_t;

  slot_t            slot_r;
  slot_t            slot_nxt_s;
  logic [DIV_W-1:0] div_r;
  logic [3:0]       sh1_r;
  logic [3:0]       sh2_r;
  logic [3:0]       sh3_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             frame_tick_r;

  logic             snap_s;
  logic             show_s;
  logic             lit_s;
  logic [3:0]       digit_s;
  logic [3:0]       an_sel_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values render as a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Slot sequencing: S1 -> S2 -> S3 -> S1
  always_comb begin
    slot_nxt_s = S1;
    case (slot_r)
      S1:      slot_nxt_s = S2;
      S2:      slot_nxt_s = S3;
      S3:      slot_nxt_s = S1;
      default: slot_nxt_s = S1;
    endcase
  end

  // Next anode/segment value from the pre-edge slot, divider and shadow digits
  always_comb begin
    digit_s  = 4'd0;
    an_sel_s = 4'b1111;
    show_s   = 1'b0;
    case (slot_r)
      S1: begin
        digit_s  = sh1_r;
        an_sel_s = 4'b1110;
        show_s   = 1'b1;
      end
      S2: begin
        digit_s  = sh2_r;
        an_sel_s = 4'b1101;
`ifdef BCD_DISP_LZB_EN
        show_s   = (sh3_r != 4'd0) || (sh2_r != 4'd0);
`else
        show_s   = 1'b1;
`endif
      end
      S3: begin
        digit_s  = sh3_r;
        an_sel_s = 4'b1011;
`ifdef BCD_DISP_LZB_EN
        show_s   = (sh3_r != 4'd0);
`else
        show_s   = 1'b1;
`endif
      end
      default: begin
        digit_s  = 4'd0;
        an_sel_s = 4'b1111;
        show_s   = 1'b0;
      end
    endcase

    // The blanking window at slot start also hides the stale shadow at the snapshot edge
    lit_s  = show_s && (div_r >= BLANK_V);
    snap_s = (slot_r == S1) && (div_r == DIV_ZERO);

    if (lit_s) begin
      an_nxt_s  = an_sel_s;
      seg_nxt_s = bcd_to_seg(digit_s);
    end else begin
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'b1111111;
    end
  end

  // Scanner state, frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      slot_r       <= S1;
      div_r        <= DIV_ZERO;
      sh1_r        <= 4'd0;
      sh2_r        <= 4'd0;
      sh3_r        <= 4'd0;
      an_r         <= 4'b1111;
      seg_r        <= 7'b1111111;
      frame_tick_r <= 1'b0;
    end else if (!en) begin
      slot_r       <= S1;
      div_r        <= DIV_ZERO;
      an_r         <= 4'b1111;
      seg_r        <= 7'b1111111;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= snap_s;
      if (snap_s) begin
        sh1_r <= dig1;
        sh2_r <= dig2;
        sh3_r <= dig3;
      end else begin
        sh1_r <= sh1_r;
        sh2_r <= sh2_r;
        sh3_r <= sh3_r;
      end
      if (div_r == DIV_LAST) begin
        div_r  <= DIV_ZERO;
        slot_r <= slot_nxt_s;
      end else begin
        div_r  <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        slot_r <= slot_r;
      end
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed bench for bcd_disp_mux with REFRESH_DIV=8, BLANK_CYCLES=2 (24-cycle frame).
// Build with +define+BCD_DISP_LZB_EN to check leading-zero blanking expectations.
module tb_bcd_disp_mux;

  logic       clk;
  logic       ar;
  logic       en;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int total;
  int bad;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  bcd_disp_mux #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .ar        (ar),
    .en        (en),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " an"}, 32'(an), 32'(4'b1111));
    check({tag, " seg"}, 32'(seg), 32'(SEG_OFF));
    check({tag, " tick"}, 32'(frame_tick), 32'(1'b0));
  endtask

  // Runs n edges from the start of a frame; x1..x3 are the expected slot patterns,
  // mask selects visible slots; at edge chg_k the inputs switch to n1..n3
  task automatic run_frame(input int n, input logic [6:0] x1, input logic [6:0] x2,
                           input logic [6:0] x3, input logic [2:0] mask, input int chg_k,
                           input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3);
    int         slot;
    int         d;
    logic       lit;
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    for (int k = 0; k < n; k++) begin
      step();
      slot = (k / 8) % 3;
      d    = k % 8;
      lit  = (d >= 2) && mask[slot];
      an_exp  = lit ? ~(4'b0001 << slot) : 4'b1111;
      seg_exp = !lit ? SEG_OFF : (slot == 0) ? x1 : (slot == 1) ? x2 : x3;
      check($sformatf("an k=%0d", k), 32'(an), 32'(an_exp));
      check($sformatf("seg k=%0d", k), 32'(seg), 32'(seg_exp));
      check($sformatf("tick k=%0d", k), 32'(frame_tick), 32'(k % 24 == 0));
      if (k == chg_k) begin
        dig1 = n1;
        dig2 = n2;
        dig3 = n3;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ar    = 1'b1;
    en    = 1'b1;
    dig1  = 4'd5;
    dig2  = 4'd5;
    dig3  = 4'd5;

    // Reset asserted with scanning requested: display must stay dark
    #2 ar = 1'b0;
    #1 check_dark("reset_async");
    repeat (3) step();
    check_dark("reset_held");

    en = 1'b0;
    ar = 1'b1;
    repeat (4) step();
    check_dark("released_en0");

    // Frame A: 3,2,1; ones digit changes to 9 during S2
    dig1 = 4'd1;
    dig2 = 4'd2;
    dig3 = 4'd3;
    en   = 1'b1;
    run_frame(24, SEG_1, SEG_2, SEG_3, 3'b111, 10, 4'd9, 4'd2, 4'd3);
    // Frame B: 9 now shown; tens changes to C right after the snapshot
    run_frame(24, SEG_9, SEG_2, SEG_3, 3'b111, 1, 4'd9, 4'hC, 4'd3);
    // Frame C: invalid tens renders as a dash
    run_frame(24, SEG_9, SEG_DASH, SEG_3, 3'b111, 3, 4'd7, 4'd0, 4'd0);
    // Frame D: leading zeros
`ifdef BCD_DISP_LZB_EN
    run_frame(24, SEG_7, SEG_0, SEG_0, 3'b001, 5, 4'd1, 4'd2, 4'd3);
`else
    run_frame(24, SEG_7, SEG_0, SEG_0, 3'b111, 5, 4'd1, 4'd2, 4'd3);
`endif
    // Frame E: stop with S2 at div=4
    run_frame(12, SEG_1, SEG_2, SEG_3, 3'b111, -1, 4'd0, 4'd0, 4'd0);
    en = 1'b0;
    step();
    check_dark("en_drop");
    step();
    check_dark("en_parked");
    // Re-enable: snapshot on first enabled edge, S1 restarts cleanly
    en = 1'b1;
    run_frame(24, SEG_1, SEG_2, SEG_3, 3'b111, -1, 4'd0, 4'd0, 4'd0);

    // Reset pulse mid-slot while S1 is lit
    run_frame(4, SEG_1, SEG_2, SEG_3, 3'b111, -1, 4'd0, 4'd0, 4'd0);
    #2 ar = 1'b0;
    #1 check_dark("ar_mid_slot");
    #2 ar = 1'b1;
    run_frame(24, SEG_1, SEG_2, SEG_3, 3'b111, -1, 4'd0, 4'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
